// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: bus layouts, load-op one-hot
// positions, exception cause bits and codes, and the stage state encoding.
package mem_pkg;

    localparam int MEM_OP_W     = 7;
    localparam int DC_TO_MEM_WD = 277 + MEM_OP_W;
    localparam int MEM_TO_WB_WD = 271;

    // one-hot load-op bit positions, {lb,lbu,lh,lhu,lw,lwl,lwr} MSB first
    localparam int OP_LB  = 6;
    localparam int OP_LBU = 5;
    localparam int OP_LH  = 4;
    localparam int OP_LHU = 3;
    localparam int OP_LW  = 2;
    localparam int OP_LWL = 1;
    localparam int OP_LWR = 0;

    localparam int EB_SYSCALL = 8;
    localparam int EB_RI      = 9;
    localparam int EB_TRAP    = 10;
    localparam int EB_OV      = 11;
    localparam int EB_ERET    = 12;
    localparam int EB_BREAK   = 13;
    localparam int EB_ADES    = 14;
    localparam int EB_ADEL_IF = 15;
    localparam int EB_ADEL    = 16;

    localparam logic [31:0] EXC_NONE = 32'h00;
    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_ADEL = 32'h04;
    localparam logic [31:0] EXC_ADES = 32'h05;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_BP   = 32'h09;
    localparam logic [31:0] EXC_RI   = 32'h0a;
    localparam logic [31:0] EXC_OV   = 32'h0c;
    localparam logic [31:0] EXC_TRAP = 32'h0d;
    localparam logic [31:0] EXC_ERET = 32'h0e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    typedef struct packed {
        logic [37:0]         cp0_bus;
        logic                delayslot;
        logic [31:0]         bad_vaddr;
        logic [31:0]         excepttype_arr;
        logic [MEM_OP_W-1:0] mem_op;
        logic [65:0]         hilo;
        logic [31:0]         pc;
        logic                ram_en;
        logic [3:0]          ram_wen;
        logic                sel_rf_res;
        logic                rf_we;
        logic [4:0]          rf_waddr;
        logic [31:0]         rt_value;
        logic [31:0]         alu_result;
    } dc_to_mem_t;

    typedef struct packed {
        logic [37:0] cp0_bus;
        logic [31:0] cp0_epc;
        logic        delayslot;
        logic [31:0] bad_vaddr;
        logic [31:0] excepttype;
        logic [65:0] hilo;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    function automatic logic [31:0] exc_encode(input logic intr, input logic [31:0] arr);
        if (intr)                           return EXC_INT;
        if (arr[EB_SYSCALL])                return EXC_SYS;
        if (arr[EB_BREAK])                  return EXC_BP;
        if (arr[EB_RI])                     return EXC_RI;
        if (arr[EB_TRAP])                   return EXC_TRAP;
        if (arr[EB_OV])                     return EXC_OV;
        if (arr[EB_ERET])                   return EXC_ERET;
        if (arr[EB_ADES])                   return EXC_ADES;
        if (arr[EB_ADEL_IF] || arr[EB_ADEL]) return EXC_ADEL;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Handshake and bus bundle between DC, the memory stage, the data port and WB.
// master = upstream/environment side, slave = the memory stage.
interface mem_stage_hs_if;
    import mem_pkg::*;

    logic        flush;
    logic        dc_valid;
    dc_to_mem_t  dc_to_mem_bus;
    logic        mem_allowin;
    logic        data_ok;
    logic [31:0] data_rdata;
    logic        wb_allowin;
    logic        mem_valid;
    mem_to_wb_t  mem_to_wb_bus;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;

    modport master (
        output flush, dc_valid, dc_to_mem_bus, data_ok, data_rdata, wb_allowin,
               cp0_status, cp0_cause, cp0_epc,
        input  mem_allowin, mem_valid, mem_to_wb_bus
    );

    modport slave (
        input  flush, dc_valid, dc_to_mem_bus, data_ok, data_rdata, wb_allowin,
               cp0_status, cp0_cause, cp0_epc,
        output mem_allowin, mem_valid, mem_to_wb_bus
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data extraction by byte offset, little-endian, incl. LWL/LWR merge.
// Zero latency; no flow control.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int HAS_UNALIGNED = 1
) (
    input  logic [MEM_OP_W-1:0] op_i,
    input  logic [1:0]          off_i,
    input  logic [31:0]         rdata_i,
    input  logic [31:0]         rt_i,
    output logic [31:0]         res_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_res;
    logic [31:0] lwr_res;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // LWL fills the upper bytes from memory, LWR the lower ones
        case (off_i)
            2'd0:    lwl_res = {rdata_i[7:0],  rt_i[23:0]};
            2'd1:    lwl_res = {rdata_i[15:0], rt_i[15:0]};
            2'd2:    lwl_res = {rdata_i[23:0], rt_i[7:0]};
            default: lwl_res = rdata_i;
        endcase
        case (off_i)
            2'd0:    lwr_res = rdata_i;
            2'd1:    lwr_res = {rt_i[31:24], rdata_i[31:8]};
            2'd2:    lwr_res = {rt_i[31:16], rdata_i[31:16]};
            default: lwr_res = {rt_i[31:8],  rdata_i[31:24]};
        endcase

        res_o = 32'h0;
        if (op_i[OP_LB])
            res_o = {{24{byte_sel[7]}}, byte_sel};
        else if (op_i[OP_LBU])
            res_o = {24'h0, byte_sel};
        else if (op_i[OP_LH])
            res_o = off_i[0] ? 32'h0 : {{16{half_sel[15]}}, half_sel};
        else if (op_i[OP_LHU])
            res_o = off_i[0] ? 32'h0 : {16'h0, half_sel};
        else if (op_i[OP_LW])
            res_o = rdata_i;
        else if (HAS_UNALIGNED != 0 && op_i[OP_LWL])
            res_o = lwl_res;
        else if (HAS_UNALIGNED != 0 && op_i[OP_LWR])
            res_o = lwr_res;
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory-access stage: holds one instruction, waits for data_ok, buffers load data, encodes exceptions.
// Latency: entry cycle plus one after data_ok (non-memory entries valid the cycle after entry).
// Backpressure: mem_allowin only when empty or when WB takes the held result; responses to flushed accesses are dropped.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int INT_LINES     = 8,
    parameter int HAS_UNALIGNED = 1,
    parameter int CANCEL_W      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_stage_hs_if.slave bus
);

    state_e               state_q, state_d;
    dc_to_mem_t           pay_q, pay_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [CANCEL_W-1:0]  cancel_q, cancel_d;

    logic        allowin, accept, wait_bound, live_ok, discard, cnt_inc, cancel_ovf;
    logic        intr;
    logic [31:0] load_res;
    logic [31:0] exc_code;
    logic        unused_bits;

    assign allowin    = (state_q == ST_EMPTY) || (state_q == ST_READY && bus.wb_allowin);
    assign accept     = bus.dc_valid && allowin;
    assign wait_bound = bus.dc_to_mem_bus.ram_en && (bus.dc_to_mem_bus.excepttype_arr[16:8] == 9'h0);
    assign discard    = bus.data_ok && (cancel_q != '0);
    assign live_ok    = bus.data_ok && (cancel_q == '0);
    // a flushed access still owes a response unless it arrives in this very cycle
    assign cnt_inc    = bus.flush && ((state_q == ST_WAIT && !live_ok) || (accept && wait_bound));
    assign cancel_ovf = cnt_inc && !discard && (cancel_q == '1);

    always_comb begin
        state_d  = state_q;
        pay_d    = pay_q;
        rdata_d  = rdata_q;
        cancel_d = cancel_q;

        if (accept)
            pay_d = bus.dc_to_mem_bus;
        if (state_q == ST_WAIT && live_ok)
            rdata_d = bus.data_rdata;

        case (state_q)
            ST_EMPTY: if (accept) state_d = wait_bound ? ST_WAIT : ST_READY;
            ST_WAIT:  if (live_ok) state_d = ST_READY;
            ST_READY: if (bus.wb_allowin)
                          state_d = !accept ? ST_EMPTY : (wait_bound ? ST_WAIT : ST_READY);
            default:  state_d = ST_EMPTY;
        endcase
        if (bus.flush)
            state_d = ST_EMPTY;

        if (discard && !cnt_inc)
            cancel_d = cancel_q - CANCEL_W'(1);
        else if (!discard && cnt_inc && cancel_q != '1)
            cancel_d = cancel_q + CANCEL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            pay_q    <= '0;
            rdata_q  <= 32'h0;
            cancel_q <= '0;
        end else begin
            state_q  <= state_d;
            pay_q    <= pay_d;
            rdata_q  <= rdata_d;
            cancel_q <= cancel_d;
        end
    end

    a_cancel_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !cancel_ovf);

    mem_load_align #(.HAS_UNALIGNED(HAS_UNALIGNED)) u_align (
        .op_i    (pay_q.mem_op),
        .off_i   (pay_q.alu_result[1:0]),
        .rdata_i (rdata_q),
        .rt_i    (pay_q.rt_value),
        .res_o   (load_res)
    );

    assign intr = bus.mem_valid
                && (|(bus.cp0_cause[8 +: INT_LINES] & bus.cp0_status[8 +: INT_LINES]))
                && !bus.cp0_status[1] && bus.cp0_status[0];
    assign exc_code = (pay_q.pc != 32'h0) ? exc_encode(intr, pay_q.excepttype_arr) : EXC_NONE;

    assign bus.mem_allowin = allowin;
    assign bus.mem_valid   = (state_q == ST_READY);

    always_comb begin
        bus.mem_to_wb_bus.cp0_bus    = pay_q.cp0_bus;
        bus.mem_to_wb_bus.cp0_epc    = bus.cp0_epc;
        bus.mem_to_wb_bus.delayslot  = pay_q.delayslot;
        bus.mem_to_wb_bus.bad_vaddr  = pay_q.bad_vaddr;
        bus.mem_to_wb_bus.excepttype = exc_code;
        bus.mem_to_wb_bus.hilo       = pay_q.hilo;
        bus.mem_to_wb_bus.pc         = pay_q.pc;
        bus.mem_to_wb_bus.rf_we      = pay_q.rf_we && (exc_code == EXC_NONE);
        bus.mem_to_wb_bus.rf_waddr   = pay_q.rf_waddr;
        bus.mem_to_wb_bus.rf_wdata   = pay_q.sel_rf_res ? load_res : pay_q.alu_result;
    end

    assign unused_bits = ^{pay_q.ram_en, pay_q.ram_wen, bus.cp0_cause, bus.cp0_status};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: handshake timing, load extraction, flush/cancel,
// backpressure hold and exception encoding, with hand-computed expectations.
module tb_mem_stage_hs;
    import mem_pkg::*;

    localparam logic [6:0] V_LB  = 7'b1000000;
    localparam logic [6:0] V_LBU = 7'b0100000;
    localparam logic [6:0] V_LH  = 7'b0010000;
    localparam logic [6:0] V_LHU = 7'b0001000;
    localparam logic [6:0] V_LW  = 7'b0000100;
    localparam logic [6:0] V_LWL = 7'b0000010;
    localparam logic [6:0] V_LWR = 7'b0000001;
    localparam logic [31:0] PC0  = 32'hBFC0_0100;

    logic clk = 1'b0;
    logic rst_n;
    int   errs   = 0;
    int   checks = 0;

    mem_stage_hs_if bus();

    mem_stage_hs #(.INT_LINES(8), .HAS_UNALIGNED(1), .CANCEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic dc_to_mem_t mk(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] rt,
                                      input logic ram_en, input logic sel, input logic we,
                                      input logic [31:0] exc, input logic [31:0] pc);
        dc_to_mem_t d = '0;
        d.mem_op         = op;
        d.alu_result     = alu;
        d.bad_vaddr      = alu;
        d.rt_value       = rt;
        d.ram_en         = ram_en;
        d.sel_rf_res     = sel;
        d.rf_we          = we;
        d.rf_waddr       = 5'd2;
        d.excepttype_arr = exc;
        d.pc             = pc;
        return d;
    endfunction

    task automatic issue(input dc_to_mem_t d);
        bus.dc_to_mem_bus = d;
        bus.dc_valid      = 1'b1;
        tick();
        bus.dc_valid      = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        bus.data_ok    = 1'b1;
        bus.data_rdata = rd;
        tick();
        bus.data_ok    = 1'b0;
        bus.data_rdata = 32'h0;
    endtask

    task automatic retire;
        bus.wb_allowin = 1'b1;
        tick();
        bus.wb_allowin = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [6:0] op, input logic [31:0] alu,
                             input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
        issue(mk(op, alu, rt, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        respond(rd);
        chk({tag, "_valid"}, {31'h0, bus.mem_valid}, 32'h1);
        chk(tag, bus.mem_to_wb_bus.rf_wdata, exp);
        retire();
    endtask

    initial begin
        dc_to_mem_t st;
        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.dc_valid   = 1'b0;
        bus.dc_to_mem_bus = '0;
        bus.data_ok    = 1'b0;
        bus.data_rdata = 32'h0;
        bus.wb_allowin = 1'b0;
        bus.cp0_status = 32'h0;
        bus.cp0_cause  = 32'h0;
        bus.cp0_epc    = 32'h0;

        #1;
        chk("rst_valid",   {31'h0, bus.mem_valid},   32'h0);
        chk("rst_allowin", {31'h0, bus.mem_allowin}, 32'h1);
        chk("rst_wdata",   bus.mem_to_wb_bus.rf_wdata,   32'h0);
        chk("rst_exc",     bus.mem_to_wb_bus.excepttype, 32'h0);
        #1 rst_n = 1'b1;
        tick();

        // lw with a three-cycle response
        issue(mk(V_LW, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        chk("t1_wait_valid",   {31'h0, bus.mem_valid},   32'h0);
        chk("t1_wait_allowin", {31'h0, bus.mem_allowin}, 32'h0);
        tick();
        tick();
        chk("t1_wait2_valid", {31'h0, bus.mem_valid}, 32'h0);
        bus.data_ok    = 1'b1;
        bus.data_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_no_comb_path", {31'h0, bus.mem_valid}, 32'h0);
        tick();
        bus.data_ok    = 1'b0;
        bus.data_rdata = 32'h0;
        chk("t1_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("t1_wdata", bus.mem_to_wb_bus.rf_wdata, 32'hDEAD_BEEF);
        chk("t1_rf_we", {31'h0, bus.mem_to_wb_bus.rf_we}, 32'h1);
        chk("t1_exc",   bus.mem_to_wb_bus.excepttype, 32'h0);
        bus.wb_allowin = 1'b1;
        #1;
        chk("t1_allowin_rel", {31'h0, bus.mem_allowin}, 32'h1);
        tick();
        bus.wb_allowin = 1'b0;
        chk("t1_empty", {31'h0, bus.mem_valid}, 32'h0);

        // extraction
        load_case("lb3",  V_LB,  32'h1003, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80);
        load_case("lbu3", V_LBU, 32'h1003, 32'h0, 32'h80FF_0000, 32'h0000_0080);
        load_case("lhu2", V_LHU, 32'h1002, 32'h0, 32'h80FF_0000, 32'h0000_80FF);
        load_case("lh2",  V_LH,  32'h1002, 32'h0, 32'h80FF_0000, 32'hFFFF_80FF);
        load_case("lh1",  V_LH,  32'h1001, 32'h0, 32'h80FF_0000, 32'h0000_0000);
        load_case("lwl1", V_LWL, 32'h1001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
        load_case("lwr1", V_LWR, 32'h1001, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
        load_case("lwl3", V_LWL, 32'h1003, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
        load_case("lwr3", V_LWR, 32'h1003, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA);

        // flush in WAIT: stale response must be dropped
        issue(mk(V_LW, 32'h2000, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t4_flush_valid",   {31'h0, bus.mem_valid},   32'h0);
        chk("t4_flush_allowin", {31'h0, bus.mem_allowin}, 32'h1);
        issue(mk(V_LW, 32'h2004, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        respond(32'h1);
        chk("t4_discard_valid", {31'h0, bus.mem_valid}, 32'h0);
        respond(32'h2);
        chk("t4_live_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("t4_live_wdata", bus.mem_to_wb_bus.rf_wdata, 32'h2);
        retire();

        // flush together with data_ok in WAIT: response consumed, nothing owed
        issue(mk(V_LW, 32'h2008, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        bus.flush = 1'b1;
        respond(32'h55);
        bus.flush = 1'b0;
        issue(mk(V_LW, 32'h200C, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        respond(32'h66);
        chk("t4b_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("t4b_wdata", bus.mem_to_wb_bus.rf_wdata, 32'h66);
        retire();

        // flush in the same cycle as a WAIT-bound accept
        bus.flush = 1'b1;
        issue(mk(V_LW, 32'h2010, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        bus.flush = 1'b0;
        chk("t4c_flush_valid", {31'h0, bus.mem_valid}, 32'h0);
        issue(mk(V_LW, 32'h2014, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        respond(32'h77);
        chk("t4c_discard_valid", {31'h0, bus.mem_valid}, 32'h0);
        respond(32'h88);
        chk("t4c_wdata", bus.mem_to_wb_bus.rf_wdata, 32'h88);
        retire();

        // WB backpressure: held result stays stable, no accept
        issue(mk(V_LW, 32'h3000, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, PC0));
        respond(32'hCAFE_F00D);
        bus.dc_to_mem_bus = mk(7'h0, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, PC0);
        bus.dc_valid      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.data_rdata = $urandom;
            tick();
            chk("t5_hold_valid",   {31'h0, bus.mem_valid},   32'h1);
            chk("t5_hold_wdata",   bus.mem_to_wb_bus.rf_wdata, 32'hCAFE_F00D);
            chk("t5_hold_allowin", {31'h0, bus.mem_allowin}, 32'h0);
        end
        bus.data_rdata = 32'h0;
        bus.wb_allowin = 1'b1;
        #1;
        chk("t5_release_allowin", {31'h0, bus.mem_allowin}, 32'h1);
        tick();
        bus.wb_allowin = 1'b0;
        bus.dc_valid   = 1'b0;
        chk("t5_next_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("t5_next_wdata", bus.mem_to_wb_bus.rf_wdata, 32'h1234);
        retire();

        // store waits for the write acknowledge, writes back alu_result
        st = mk(7'h0, 32'hABC0, 32'h5555, 1'b1, 1'b0, 1'b0, 32'h0, PC0);
        st.ram_wen = 4'hF;
        issue(st);
        tick();
        chk("st_wait_valid", {31'h0, bus.mem_valid}, 32'h0);
        respond(32'h0);
        chk("st_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("st_wdata", bus.mem_to_wb_bus.rf_wdata, 32'hABC0);
        retire();

        // exceptions: interrupt over syscall, EXL masks interrupt
        bus.cp0_status = 32'h0000_0401;
        bus.cp0_cause  = 32'h0000_0400;
        bus.cp0_epc    = 32'hBFC0_0380;
        issue(mk(7'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, PC0));
        chk("t6_direct_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("t6_int_exc",      bus.mem_to_wb_bus.excepttype, 32'h01);
        chk("t6_int_rf_we",    {31'h0, bus.mem_to_wb_bus.rf_we}, 32'h0);
        chk("t6_epc",          bus.mem_to_wb_bus.cp0_epc, 32'hBFC0_0380);
        bus.cp0_status = 32'h0000_0403;
        #1;
        chk("t6_exl_exc",   bus.mem_to_wb_bus.excepttype, 32'h08);
        chk("t6_exl_rf_we", {31'h0, bus.mem_to_wb_bus.rf_we}, 32'h0);
        retire();

        bus.cp0_status = 32'h0;
        bus.cp0_cause  = 32'h0;
        issue(mk(7'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_2200, PC0));
        chk("t6_break_over_ri", bus.mem_to_wb_bus.excepttype, 32'h09);
        retire();
        issue(mk(7'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0001_0800, PC0));
        chk("t6_ov_over_adel", bus.mem_to_wb_bus.excepttype, 32'h0c);
        retire();
        issue(mk(7'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0001_0000, 32'h0));
        chk("t6_pc0_exc",   bus.mem_to_wb_bus.excepttype, 32'h00);
        chk("t6_pc0_rf_we", {31'h0, bus.mem_to_wb_bus.rf_we}, 32'h1);
        retire();

        // highest interrupt line, then with IE cleared
        bus.cp0_status = 32'h0000_8001;
        bus.cp0_cause  = 32'h0000_8000;
        issue(mk(7'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, PC0));
        chk("t6_top_line", bus.mem_to_wb_bus.excepttype, 32'h01);
        bus.cp0_status = 32'h0000_8000;
        #1;
        chk("t6_ie_off", bus.mem_to_wb_bus.excepttype, 32'h00);
        chk("t6_ie_off_rf_we", {31'h0, bus.mem_to_wb_bus.rf_we}, 32'h1);
        retire();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
